// File: rtl/pc_fetch_pkg.sv
// Shared bus widths and next-PC source encodings for the fetch stage.
package pc_fetch_pkg;

  localparam int unsigned ADDRESS_BUS_WIDTH = 16;
  localparam int unsigned DATA_BUS_WIDTH    = 16;

  // Next-PC source select, fed to the mux4
  typedef enum logic [1:0] {
    SelSeq    = 2'd0,
    SelBranch = 2'd1,
    SelJump   = 2'd2,
    SelIrq    = 2'd3
  } pc_sel_e;

  // Priority: irq > jump > branch > sequential
  function automatic pc_sel_e pc_sel_encode(input logic irq, input logic jump,
                                            input logic branch_taken);
    if (irq) begin
      return SelIrq;
    end else if (jump) begin
      return SelJump;
    end else if (branch_taken) begin
      return SelBranch;
    end
    return SelSeq;
  endfunction

endpackage

// File: rtl/pc_fetch_mux4.sv
// Generic 4:1 multiplexer used for next-PC selection.
module pc_fetch_mux4 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  output logic [WIDTH-1:0] out_o
);

  // Pure combinational select
  always_comb begin
    out_o = in0_i;
    case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      default: out_o = in3_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, redirect handling and a one-entry
// instruction holding slot towards decode.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH        = ADDRESS_BUS_WIDTH,
  parameter int unsigned      DWIDTH       = DATA_BUS_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [WIDTH-1:0]  branch_target,
  input  logic              jump,
  input  logic [WIDTH-1:0]  jump_target,
  input  logic              irq,
  output logic              mem_req,
  output logic [WIDTH-1:0]  mem_addr,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] instr,
  output logic [WIDTH-1:0]  instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WIDTH-1:0]  pc
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StFlush = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [DWIDTH-1:0]  instr_q, instr_d;
  logic [WIDTH-1:0]   instr_pc_q, instr_pc_d;

  pc_sel_e            sel;
  logic               redirect;
  logic [WIDTH-1:0]   next_pc;
  logic [WIDTH-1:0]   pc_inc;

  assign redirect = irq | jump | branch_taken;
  assign sel      = pc_sel_encode(irq, jump, branch_taken);
  // Natural wrap modulo 2^WIDTH
  assign pc_inc   = pc_q + WIDTH'(1);

  pc_fetch_mux4 #(
    .WIDTH (WIDTH)
  ) u_next_pc_mux (
    .sel_i (sel),
    .in0_i (pc_inc),
    .in1_i (branch_target),
    .in2_i (jump_target),
    .in3_i (IRQ_VECTOR),
    .out_o (next_pc)
  );

  // Next-state: fetch/flush/hold sequencing and PC updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      StFetch: begin
        if (mem_ack) begin
          // With a redirect the returned word belongs to a dead path
          pc_d = next_pc;
          if (!redirect) begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            state_d    = StHold;
          end
        end else if (redirect) begin
          // Request is in flight; keep the address and wait it out
          pend_d  = next_pc;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (mem_ack) begin
          pc_d    = redirect ? next_pc : pend_q;
          state_d = StFetch;
        end else if (redirect) begin
          pend_d = next_pc;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = StFetch;
        end else if (instr_ready) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Reset gates the request directly so it drops without waiting for a clock
  assign mem_req     = (state_q != StHold) && !reset;
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule
